// File: rtl/kitchen_responder_if.sv
// kitchen_responder_if: command/status link between a kitchen controller and the responder.
//   in_bits  [7:0] command byte, driven by the controller
//   out_bits [7:0] status byte, driven by the responder
//   score    [7:0] delivered-dish count, driven by the responder
// Also defines the shared command byte constants used on in_bits.
`ifndef START
`define START    8'h04
`define ENDGAME  8'h08
`define MOVE     8'h0C
`define GET      8'h10
`define PUT      8'h14
`define INTERACT 8'h18
`define THROW    8'h1C
`define NONACT   8'h00
`define NONINT   8'h20
`define NONTAR   8'h24
`endif

interface kitchen_responder_if;
  logic [7:0] in_bits;
  logic [7:0] out_bits;
  logic [7:0] score;
  modport master (output in_bits, input out_bits, score);
  modport slave (input in_bits, output out_bits, score);
endinterface

// File: rtl/kitchen_responder.sv
// kitchen_responder: behavioural kitchen client answering the 8-bit command link.
//   clk, rst   clock and synchronous active-high reset
//   bus.slave  in_bits (command), out_bits (status), score (dishes served)
//   out_bits = {2'b0, target_has_item, machine_processing, holding, at_target, ack, running}
// Optional feature macro RESPONDER_SCORE_EN: target 20 becomes the serving window
// and counts deliveries into score; otherwise target 20 is plain storage and score stays 0.
module kitchen_responder #(
  parameter int MOVE_CYCLES = 16,
  parameter int PROCESS_CYCLES = 8,
  parameter int NUM_TARGETS = 20
) (
  input logic clk,
  input logic rst,
  kitchen_responder_if.slave bus
);
  localparam int IW = $clog2(NUM_TARGETS + 1);
  localparam int MW = $clog2(MOVE_CYCLES + 1);
  localparam int PW = $clog2(PROCESS_CYCLES + 1);
  localparam logic [5:0] NT = 6'(NUM_TARGETS);
`ifdef RESPONDER_SCORE_EN
  localparam logic SCORE_EN = 1'b1;
`else
  localparam logic SCORE_EN = 1'b0;
`endif
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [7:0] prev_q, out_q, out_d, score_q, score_d;
  logic [IW-1:0] target_q, target_d;
  logic at_q, at_d, hold_q, hold_d;
  logic [MW-1:0] mcnt_q, mcnt_d;
  logic [NUM_TARGETS:0] flag_q, flag_d;
  logic [PW-1:0] prog_q [NUM_TARGETS+1];
  logic [PW-1:0] prog_d [NUM_TARGETS+1];
  logic [7:0] cmd;
  logic [5:0] id, t, td;
  logic acc, run, is_disp, is_mach, need_clr, serve, can_get, can_put, can_throw, ack;
  assign cmd = bus.in_bits;
  assign id = cmd[7:2];
  assign t = 6'(target_q);
  // A command acts only on the cycle the byte changes; interact is handled separately.
  assign acc = cmd != prev_q;
  assign run = state_q == RUN;
  assign is_disp = t >= 6'd1 && t <= 6'd6;
  assign is_mach = t >= 6'd9 && t <= 6'd17;
  assign need_clr = t == 6'd7 || t == 6'd8 || t == 6'd20;
  assign serve = SCORE_EN && t == 6'd20;
  // Bin 18 accepts items but never gives them back.
  assign can_get = at_q && !hold_q && (is_disp || (t >= 6'd7 && t <= NT && t != 6'd18 && flag_q[target_q]));
  assign can_put = at_q && hold_q && !(need_clr && flag_q[target_q]);
  assign can_throw = hold_q && !flag_q[target_q] &&
                     (t == 6'd9 || t == 6'd11 || t == 6'd14 || t == 6'd17 || t == 6'd19 || t == 6'd20);
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (acc && !run && cmd == `START) state_d = RUN;
    else if (acc && run && cmd == `ENDGAME) state_d = IDLE;
  end
  always_comb begin
    target_d = target_q;
    at_d = at_q;
    hold_d = hold_q;
    mcnt_d = mcnt_q;
    flag_d = flag_q;
    prog_d = prog_q;
    score_d = score_q;
    ack = 1'b0;
    if (run && mcnt_q != '0) begin
      mcnt_d = mcnt_q - 1'b1;
      if (mcnt_q == MW'(1)) at_d = 1'b1;
    end
    if (!run) begin
      if (acc && cmd == `START) begin
        flag_d = '0;
        score_d = '0;
      end
    end else if (cmd[1:0] == 2'b11) begin
      // Any select aborts a move in flight, so it also beats a same-cycle arrival.
      if (acc) begin
        target_d = (id != 6'd0 && id <= NT) ? IW'(id) : '0;
        at_d = 1'b0;
        mcnt_d = '0;
      end
    end else if (acc && cmd == `ENDGAME) begin
      hold_d = 1'b0;
      at_d = 1'b0;
      mcnt_d = '0;
    end else if (acc && cmd == `MOVE) begin
      if (target_q != '0) begin
        mcnt_d = MW'(MOVE_CYCLES);
        at_d = 1'b0;
      end
    end else if (acc && cmd == `GET && can_get) begin
      hold_d = 1'b1;
      if (!is_disp) flag_d[target_q] = 1'b0;
      ack = 1'b1;
    end else if (acc && ((cmd == `PUT && can_put) || (cmd == `THROW && can_throw))) begin
      hold_d = 1'b0;
      if (serve) score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
      else if (!is_disp) flag_d[target_q] = 1'b1;
      ack = 1'b1;
    end else if (cmd == `INTERACT && at_q && is_mach) begin
      prog_d[target_q] = prog_q[target_q] + 1'b1;
      if (prog_d[target_q] == PW'(PROCESS_CYCLES)) begin
        prog_d[target_q] = '0;
        flag_d[target_q] = 1'b1;
      end
      ack = 1'b1;
    end
    // Status is a registered image of the next state.
    td = 6'(target_d);
    out_d = {2'b00, flag_d[target_d],
             td >= 6'd9 && td <= 6'd17 && prog_d[target_d] != '0 && !flag_d[target_d],
             hold_d, at_d, ack, state_d == RUN};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      out_q <= '0;
      score_q <= '0;
      target_q <= '0;
      at_q <= 1'b0;
      hold_q <= 1'b0;
      mcnt_q <= '0;
      flag_q <= '0;
      prog_q <= '{default: '0};
    end else begin
      prev_q <= cmd;
      out_q <= out_d;
      score_q <= score_d;
      target_q <= target_d;
      at_q <= at_d;
      hold_q <= hold_d;
      mcnt_q <= mcnt_d;
      flag_q <= flag_d;
      prog_q <= prog_d;
    end
  end
  assign bus.out_bits = out_q;
  assign bus.score = score_q;
endmodule
